// File: rtl/part_univ_shreg.sv
// Universal WIDTH-bit register (hold / shift right / shift left / load, optional rotate)
// with an auto-shift sequencer that runs a programmed count of shifts and pulses DONE.
module part_univ_shreg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             EN,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             SR,
    input  logic             SL,
    input  logic             ROT,
    input  logic             START,
    input  logic             DIR,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_dir;

    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    // ROT is applied live on every shift, both manual and automatic
    assign w_shr = {(ROT ? r_q[0] : SR), r_q[WIDTH-1:1]};
    assign w_shl = {r_q[WIDTH-2:0], (ROT ? r_q[WIDTH-1] : SL)};

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dir  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (EN) begin
                if (r_busy) begin
                    r_q   <= r_dir ? w_shl : w_shr;
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end else if (START) begin
                    // Q holds on the start edge; a zero count completes immediately
                    r_dir  <= DIR;
                    r_rem  <= CNT;
                    r_busy <= (CNT != '0);
                    r_done <= (CNT == '0);
                end else begin
                    case (S)
                        2'b01:   r_q <= w_shr;
                        2'b10:   r_q <= w_shl;
                        2'b11:   r_q <= D;
                        default: r_q <= r_q;
                    endcase
                end
            end
        end
    end

    assign Q    = r_q;
    assign SO_R = r_q[0];
    assign SO_L = r_q[WIDTH-1];
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule
